// File: rtl/wb_port_arbiter_if.sv
// wb_port_arbiter_if: bundle of the writeback, mul/div and regfile-port
// signals around the write-port arbiter.
//   slave  : arbiter side (consumes pipe_*/md_*, produces stall/ready/rf_*)
//   master : pipeline / mul-div / regfile side
interface wb_port_arbiter_if #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              pipe_regwrite;
    logic [ADDR_W-1:0] pipe_wa;
    logic [DATA_W-1:0] pipe_wd;
    logic              pipe_stall;
    logic              md_valid;
    logic              md_ready;
    logic [ADDR_W-1:0] md_wa;
    logic [DATA_W-1:0] md_wd;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [CNT_W-1:0]  pend_count;

    modport slave (
        input  pipe_regwrite, pipe_wa, pipe_wd, md_valid, md_wa, md_wd,
        output pipe_stall, md_ready, rf_we, rf_wa, rf_wd, pend_count
    );

    modport master (
        output pipe_regwrite, pipe_wa, pipe_wd, md_valid, md_wa, md_wd,
        input  pipe_stall, md_ready, rf_we, rf_wa, rf_wd, pend_count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single regfile write port between the in-order
// writeback stage and the mul/div unit.
//   - Pipeline writes normally own the port; mul/div results are queued in a
//     DEPTH-entry FIFO and drain on cycles the pipe does not write.
//   - A starve counter stalls writeback once the FIFO head has been refused
//     STARVE_LIMIT times; a pending result to the same register as the pipe
//     write also stalls the pipe so the older value lands first.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : wb_port_arbiter_if.slave (pipe_*, md_*, rf_*, pend_count)
// Optional: `define WB_ARB_BYPASS_EN lets a result write the port directly
// in its acceptance cycle when the FIFO is empty and the pipe is idle.
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 5
) (
    input logic                clk,
    input logic                reset,
    wb_port_arbiter_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    logic [DEPTH-1:0][ADDR_W-1:0] q_wa;
    logic [DEPTH-1:0][DATA_W-1:0] q_wd;
    logic [PTR_W-1:0]             rd_ptr, wr_ptr;
    logic [CNT_W-1:0]             count;
    logic [STV_W-1:0]             starve;

    logic             pw, head, waw, starved, grant_head, byp, accept, enq, deq;
    logic [PTR_W-1:0] off;

    assign pw      = bus.pipe_regwrite && (bus.pipe_wa != '0);
    assign head    = (count != '0);
    assign starved = (starve == STV_W'(STARVE_LIMIT));

    // Ready is based on occupancy only, never on a same-cycle dequeue.
    assign bus.md_ready = (count < CNT_W'(DEPTH)) && !reset;
    assign accept       = bus.md_valid && bus.md_ready;

    // Same-address check against every live entry; slot i is live when its
    // distance from rd_ptr is below the occupancy.
    always_comb begin
        waw = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = PTR_W'(i) - rd_ptr;
            if ((CNT_W'(off) < count) && (q_wa[i] == bus.pipe_wa))
                waw = 1'b1;
        end
    end

`ifdef WB_ARB_BYPASS_EN
    assign byp = !head && !pw && bus.md_valid && (bus.md_wa != '0) && !reset;
`else
    assign byp = 1'b0;
`endif

    assign grant_head = head && (!pw || waw || starved);
    assign deq        = grant_head;
    // Results to x0 are acknowledged but never stored.
    assign enq        = accept && (bus.md_wa != '0) && !byp;

    always_comb begin
        bus.rf_we      = pw;
        bus.rf_wa      = bus.pipe_wa;
        bus.rf_wd      = bus.pipe_wd;
        bus.pipe_stall = 1'b0;
        if (grant_head) begin
            bus.rf_we      = 1'b1;
            bus.rf_wa      = q_wa[rd_ptr];
            bus.rf_wd      = q_wd[rd_ptr];
            bus.pipe_stall = pw;
        end else if (byp) begin
            bus.rf_we = 1'b1;
            bus.rf_wa = bus.md_wa;
            bus.rf_wd = bus.md_wd;
        end
    end

    assign bus.pend_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(enq) - CNT_W'(deq);
            // A refused head ages the counter; any drain or an empty queue
            // restarts it.
            if (deq || !head)
                starve <= '0;
            else if (!starved)
                starve <= starve + 1'b1;
        end
    end

    // Payload storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_wa[wr_ptr] <= bus.md_wa;
            q_wd[wr_ptr] <= bus.md_wd;
        end
    end
endmodule
